// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants, stage-entry type and helpers for the mult pipeline controller
package mult_pkg;

    localparam int MUL_LAT = 5;
    localparam int ALU_LAT = 2;

    // Zero-based index of the stage whose writeback lands in the same cycle as a new non-mult op
    localparam int CONFLICT_IDX = MUL_LAT - ALU_LAT - 1;

    localparam int CNT_W = $clog2(MUL_LAT + 1);

    localparam logic [6:0] MUL_FUNCT7 = 7'b0000001;
    localparam logic [6:0] MUL_OPCODE = 7'b0110011;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       rd_we;
    } stage_t;

    // Decode helper for the issue stage that produces iss_is_mul_i
    function automatic logic is_mul_op(input logic [6:0] funct7, input logic [6:0] opcode);
        return (funct7 == MUL_FUNCT7) && (opcode == MUL_OPCODE);
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [MUL_LAT-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MUL_LAT; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/mult_hazard_cmp.sv
// rtl/mult_hazard_cmp.sv - compares one source register against every mult stage entry
module mult_hazard_cmp
    import mult_pkg::*;
(
    input  logic [4:0]               rs_i,
    input  stage_t [MUL_LAT-1:0]     stages_i,
    output logic [MUL_LAT-1:0]       hit_o
);

    // x0 never matches: it is hardwired zero, so a pending write to it is harmless
    always_comb begin
        hit_o = '0;
        for (int k = 0; k < MUL_LAT; k++) begin
            hit_o[k] = (rs_i != 5'd0) && stages_i[k].valid && stages_i[k].rd_we
                       && (stages_i[k].rd == rs_i);
        end
    end

endmodule

// File: rtl/mult_pipe_ctrl.sv
// rtl/mult_pipe_ctrl.sv - mult pipeline scoreboard, hazard/stall and writeback control (option: MULT_PIPE_CTRL_BYPASS_EN)
module mult_pipe_ctrl
    import mult_pkg::*;
(
    input  logic       clk_i,
    input  logic       rsn_i,
    input  logic       kill_i,
    input  logic       iss_valid_i,
    input  logic       iss_is_mul_i,
    input  logic [4:0] iss_rd_i,
    input  logic       iss_rd_we_i,
    input  logic [4:0] iss_rs1_i,
    input  logic [4:0] iss_rs2_i,
    output logic       stall_o,
    output logic       wb_sel_mul_o,
    output logic [4:0] wb_addr_o,
    output logic       wb_we_o,
    output logic       byp_rs1_o,
    output logic       byp_rs2_o,
    output logic       busy_o,
    output logic [2:0] inflight_o
);

    stage_t [MUL_LAT-1:0] stage_q;
    stage_t [MUL_LAT-1:0] stage_d;

    logic [MUL_LAT-1:0] hit_rs1;
    logic [MUL_LAT-1:0] hit_rs2;
    logic [MUL_LAT-1:0] valid_vec;
    logic               raw_hazard;
    logic               wb_conflict;
    logic               issue_mul;

`ifdef MULT_PIPE_CTRL_BYPASS_EN
    // The last stage is forwarded instead of waited on
    localparam logic [MUL_LAT-1:0] HAZ_WIN = {1'b0, {(MUL_LAT-1){1'b1}}};
`else
    localparam logic [MUL_LAT-1:0] HAZ_WIN = {MUL_LAT{1'b1}};
`endif

    mult_hazard_cmp u_cmp_rs1 (
        .rs_i     (iss_rs1_i),
        .stages_i (stage_q),
        .hit_o    (hit_rs1)
    );

    mult_hazard_cmp u_cmp_rs2 (
        .rs_i     (iss_rs2_i),
        .stages_i (stage_q),
        .hit_o    (hit_rs2)
    );

    // Stall decision: RAW on an in-flight mult, or a non-mult that would collide at writeback
    always_comb begin
        raw_hazard  = iss_valid_i && (|((hit_rs1 | hit_rs2) & HAZ_WIN));
        wb_conflict = iss_valid_i && !iss_is_mul_i && iss_rd_we_i
                      && stage_q[CONFLICT_IDX].valid && stage_q[CONFLICT_IDX].rd_we;
        stall_o     = raw_hazard || wb_conflict;
        issue_mul   = iss_valid_i && iss_is_mul_i && !stall_o && !kill_i;
`ifdef MULT_PIPE_CTRL_BYPASS_EN
        byp_rs1_o   = iss_valid_i && hit_rs1[MUL_LAT-1];
        byp_rs2_o   = iss_valid_i && hit_rs2[MUL_LAT-1];
`else
        byp_rs1_o   = 1'b0;
        byp_rs2_o   = 1'b0;
`endif
    end

    // Next stage contents: shift every cycle, S1 only takes a surviving mult issue
    always_comb begin
        stage_d    = '0;
        if (issue_mul) begin
            stage_d[0].valid = 1'b1;
            stage_d[0].rd    = iss_rd_i;
            stage_d[0].rd_we = iss_rd_we_i;
        end
        for (int k = 1; k < MUL_LAT; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    // Stage register; reset drops every in-flight entry so nothing writes back afterwards
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Writeback and occupancy status straight from the stage register
    always_comb begin
        for (int k = 0; k < MUL_LAT; k++) begin
            valid_vec[k] = stage_q[k].valid;
        end
        wb_sel_mul_o = stage_q[MUL_LAT-1].valid;
        wb_addr_o    = stage_q[MUL_LAT-1].rd;
        wb_we_o      = stage_q[MUL_LAT-1].valid && stage_q[MUL_LAT-1].rd_we;
        busy_o       = |valid_vec;
        inflight_o   = popcount(valid_vec);
    end

endmodule

// File: tb/tb_mult_pipe_ctrl.sv
// tb/tb_mult_pipe_ctrl.sv - scoreboard bench for mult_pipe_ctrl (expectations follow MULT_PIPE_CTRL_BYPASS_EN)
module tb_mult_pipe_ctrl;

    logic       clk_i;
    logic       rsn_i;
    logic       kill_i;
    logic       iss_valid_i;
    logic       iss_is_mul_i;
    logic [4:0] iss_rd_i;
    logic       iss_rd_we_i;
    logic [4:0] iss_rs1_i;
    logic [4:0] iss_rs2_i;
    logic       stall_o;
    logic       wb_sel_mul_o;
    logic [4:0] wb_addr_o;
    logic       wb_we_o;
    logic       byp_rs1_o;
    logic       byp_rs2_o;
    logic       busy_o;
    logic [2:0] inflight_o;

    mult_pipe_ctrl dut (
        .clk_i        (clk_i),
        .rsn_i        (rsn_i),
        .kill_i       (kill_i),
        .iss_valid_i  (iss_valid_i),
        .iss_is_mul_i (iss_is_mul_i),
        .iss_rd_i     (iss_rd_i),
        .iss_rd_we_i  (iss_rd_we_i),
        .iss_rs1_i    (iss_rs1_i),
        .iss_rs2_i    (iss_rs2_i),
        .stall_o      (stall_o),
        .wb_sel_mul_o (wb_sel_mul_o),
        .wb_addr_o    (wb_addr_o),
        .wb_we_o      (wb_we_o),
        .byp_rs1_o    (byp_rs1_o),
        .byp_rs2_o    (byp_rs2_o),
        .busy_o       (busy_o),
        .inflight_o   (inflight_o)
    );

    typedef struct {
        int         cyc;
        logic [6:0] exp;
    } chk_t;

    typedef struct {
        int         cyc;
        logic [4:0] addr;
    } wb_t;

    chk_t chk_q[$];
    wb_t  wb_q[$];
    chk_t m_c;
    wb_t  m_w;
    logic [6:0] m_act;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drv(input bit v, input bit m, input int rd, input bit we,
                       input int rs1, input int rs2, input bit k);
        iss_valid_i  = v;
        iss_is_mul_i = m;
        iss_rd_i     = 5'(rd);
        iss_rd_we_i  = we;
        iss_rs1_i    = 5'(rs1);
        iss_rs2_i    = 5'(rs2);
        kill_i       = k;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Expected {stall, byp_rs1, byp_rs2, busy, inflight} for the current cycle
    task automatic exp_o(input bit st, input bit b1, input bit b2, input int inf);
        chk_t c;
        c.cyc = cyc;
        c.exp = {st, b1, b2, (inf != 0), 3'(inf)};
        chk_q.push_back(c);
    endtask

    task automatic exp_wb(input int dly, input int addr);
        wb_t w;
        w.cyc  = cyc + dly;
        w.addr = 5'(addr);
        wb_q.push_back(w);
    endtask

    // Monitor: compares presented outputs against the queued expectations
    always @(negedge clk_i) begin
        while (chk_q.size() > 0 && chk_q[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL out_missed cyc=%0d expected_cyc=%0d", cyc, chk_q[0].cyc);
            void'(chk_q.pop_front());
        end
        if (chk_q.size() > 0 && chk_q[0].cyc == cyc) begin
            m_c   = chk_q.pop_front();
            m_act = {stall_o, byp_rs1_o, byp_rs2_o, busy_o, inflight_o};
            total++;
            if (m_act !== m_c.exp) begin
                bad++;
                $display("FAIL outputs cyc=%0d got{stall,b1,b2,busy,infl}=%b want=%b",
                         cyc, m_act, m_c.exp);
            end
        end
        if (wb_sel_mul_o || wb_we_o) begin
            total++;
            if (wb_q.size() == 0 || wb_q[0].cyc != cyc) begin
                bad++;
                $display("FAIL wb_unexpected cyc=%0d got sel=%b we=%b addr=%0d want none",
                         cyc, wb_sel_mul_o, wb_we_o, wb_addr_o);
            end else begin
                m_w = wb_q.pop_front();
                if ({wb_sel_mul_o, wb_we_o, wb_addr_o} !== {1'b1, 1'b1, m_w.addr}) begin
                    bad++;
                    $display("FAIL wb_data cyc=%0d got sel=%b we=%b addr=%0d want sel=1 we=1 addr=%0d",
                             cyc, wb_sel_mul_o, wb_we_o, wb_addr_o, m_w.addr);
                end
            end
        end
        while (wb_q.size() > 0 && wb_q[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL wb_missed cyc=%0d want addr=%0d at cyc=%0d", cyc, wb_q[0].addr, wb_q[0].cyc);
            void'(wb_q.pop_front());
        end
    end

    initial begin
        rsn_i = 1'b0;
        idle();

        // Reset: outputs stay 0 even with an issuing instruction
        step(); drv(1, 1, 5, 1, 5, 5, 0); exp_o(0, 0, 0, 0);
        step(); idle();                   exp_o(0, 0, 0, 0);
        step(); rsn_i = 1'b1;             exp_o(0, 0, 0, 0);

        // Back-to-back mults rd=5 then rd=6
        step(); drv(1, 1, 5, 1, 1, 2, 0); exp_o(0, 0, 0, 0); exp_wb(5, 5);
        step(); drv(1, 1, 6, 1, 3, 4, 0); exp_o(0, 0, 0, 1); exp_wb(5, 6);
        step(); idle(); exp_o(0, 0, 0, 2);
        step(); idle(); exp_o(0, 0, 0, 2);
        step(); idle(); exp_o(0, 0, 0, 2);
        step(); idle(); exp_o(0, 0, 0, 2);
        step(); idle(); exp_o(0, 0, 0, 1);
        step(); idle(); exp_o(0, 0, 0, 0);

        // RAW: MUL rd=7 then ADD rs1=7
        step(); drv(1, 1, 7, 1, 1, 2, 0); exp_o(0, 0, 0, 0); exp_wb(5, 7);
        for (int i = 0; i < 4; i++) begin
            step(); drv(1, 0, 8, 1, 7, 0, 0); exp_o(1, 0, 0, 1);
        end
`ifdef MULT_PIPE_CTRL_BYPASS_EN
        step(); drv(1, 0, 8, 1, 7, 0, 0); exp_o(0, 1, 0, 1);
        step(); idle();                   exp_o(0, 0, 0, 0);
`else
        step(); drv(1, 0, 8, 1, 7, 0, 0); exp_o(1, 0, 0, 1);
        step(); drv(1, 0, 8, 1, 7, 0, 0); exp_o(0, 0, 0, 0);
        step(); idle();                   exp_o(0, 0, 0, 0);
`endif

        // Writeback conflict: MUL rd=3, independent ADD rd=9 three cycles later
        step(); drv(1, 1, 3, 1, 1, 2, 0); exp_o(0, 0, 0, 0); exp_wb(5, 3);
        step(); idle();                   exp_o(0, 0, 0, 1);
        step(); idle();                   exp_o(0, 0, 0, 1);
        step(); drv(1, 0, 9, 1, 1, 2, 0); exp_o(1, 0, 0, 1);
        step(); drv(1, 0, 9, 1, 1, 2, 0); exp_o(0, 0, 0, 1);
        step(); idle();                   exp_o(0, 0, 0, 1);
        step(); idle();                   exp_o(0, 0, 0, 0);

        // A mult in the same slot never stalls for writeback
        step(); drv(1, 1, 3, 1, 1, 2, 0);  exp_o(0, 0, 0, 0); exp_wb(5, 3);
        step(); idle();                    exp_o(0, 0, 0, 1);
        step(); idle();                    exp_o(0, 0, 0, 1);
        step(); drv(1, 1, 10, 1, 1, 2, 0); exp_o(0, 0, 0, 1); exp_wb(5, 10);
        step(); idle(); exp_o(0, 0, 0, 2);
        step(); idle(); exp_o(0, 0, 0, 2);
        step(); idle(); exp_o(0, 0, 0, 1);
        step(); idle(); exp_o(0, 0, 0, 1);
        step(); idle(); exp_o(0, 0, 0, 1);
        step(); idle(); exp_o(0, 0, 0, 0);

        // Kill suppresses the S1 load
        step(); drv(1, 1, 4, 1, 1, 2, 1); exp_o(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(); idle(); exp_o(0, 0, 0, 0);
        end

        // Kill does not mask stall nor touch in-flight stages; rs2 path
        step(); drv(1, 1, 11, 1, 1, 2, 0);  exp_o(0, 0, 0, 0); exp_wb(5, 11);
        step(); drv(1, 0, 12, 1, 1, 11, 1); exp_o(1, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(); idle(); exp_o(0, 0, 0, 1);
        end
        step(); idle(); exp_o(0, 0, 0, 0);

        // Reset mid-flight: three mults dropped, no writeback after
        step(); drv(1, 1, 12, 1, 1, 2, 0); exp_o(0, 0, 0, 0);
        step(); drv(1, 1, 13, 1, 1, 2, 0); exp_o(0, 0, 0, 1);
        step(); drv(1, 1, 14, 1, 1, 2, 0); exp_o(0, 0, 0, 2);
        step(); idle();                    exp_o(0, 0, 0, 3);
        step(); rsn_i = 1'b0;              exp_o(0, 0, 0, 0);
        step(); rsn_i = 1'b1;              exp_o(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(); idle(); exp_o(0, 0, 0, 0);
        end

        // x0 destination never creates a hazard
        step(); drv(1, 1, 0, 1, 1, 2, 0); exp_o(0, 0, 0, 0); exp_wb(5, 0);
        step(); drv(1, 0, 1, 1, 0, 0, 0); exp_o(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(); idle(); exp_o(0, 0, 0, 1);
        end
        step(); idle(); exp_o(0, 0, 0, 0);

        repeat (3) step();

        total++;
        if (chk_q.size() != 0 || wb_q.size() != 0) begin
            bad++;
            $display("FAIL drain got chk_left=%0d wb_left=%0d want 0 0", chk_q.size(), wb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_pipe_ctrl.md
MULT_PIPE_CTRL -- requirements
Module: mult_pipe_ctrl

Interface
REQ-001 SHALL have ports, in order:
- clk_i  in  1  clock
- rsn_i  in  1  reset; one clock; reset is asynchronous and active-low
- kill_i  in  1  squash current issue-stage instruction
- iss_valid_i  in  1  instruction present in issue stage
- iss_is_mul_i  in  1  instruction is M-extension (funct7=0000001, opcode=0110011)
- iss_rd_i  in  5  destination register
- iss_rd_we_i  in  1  instruction writes rd
- iss_rs1_i  in  5  source 1
- iss_rs2_i  in  5  source 2
- stall_o  out  1  hold issue stage this cycle
- wb_sel_mul_o  out  1  shared writeback port owned by mult path
- wb_addr_o  out  5  mult writeback register
- wb_we_o  out  1  mult writeback enable
- byp_rs1_o  out  1  forward mult result to rs1
- byp_rs2_o  out  1  forward mult result to rs2
- busy_o  out  1  any mult entry in flight
- inflight_o  out  3  number of valid mult entries, 0..5

REQ-002 SHALL have constants, with name, default and meaning:
- MUL_LAT  5  issue-to-writeback cycles for mult ops
- ALU_LAT  2  issue-to-writeback cycles for non-mult ops

Function
REQ-003 SHALL track MUL_LAT stages S1..S5; each stage holds valid, rd and rd_we.
REQ-004 SHALL advance stages every cycle unconditionally: S(k+1) <= S(k), and S5 retires.
REQ-005 SHALL load S1 at the clock edge ending cycle t, with rd and rd_we, only when iss_valid_i, iss_is_mul_i, !stall_o and !kill_i; otherwise S1.valid <= 0.
REQ-006 SHALL drive wb_sel_mul_o = S5.valid, wb_addr_o = S5.rd and wb_we_o = S5.valid & S5.rd_we, all combinational from the stage register. A mult issued in cycle t therefore writes back in cycle t+5.
REQ-007 SHALL detect a RAW hazard when iss_valid_i is set and a nonzero rs1 or rs2 equals rd of any stage in the hazard window whose valid and rd_we are both set.
- Hazard window is S1..S5 without the bypass.
REQ-008 SHALL detect a writeback conflict when iss_valid_i is set, iss_is_mul_i is clear, iss_rd_we_i is set, and stage S(MUL_LAT-ALU_LAT)=S3 has valid and rd_we set.
- In that case both writers would target WB in the same cycle.
REQ-009 SHALL drive stall_o = RAW hazard | writeback conflict, combinationally; kill_i does not mask stall_o.
REQ-010 SHALL never stall a mult issue for writeback reasons, because mult writebacks are always later than all earlier non-mult writebacks.
REQ-011 SHALL leave stages S1..S5 unaffected by kill_i; only the S1 load is suppressed.
REQ-012 SHALL drive busy_o = OR of all stage valids, and inflight_o = popcount of the stage valids.
REQ-013 SHALL treat rd = x0 as a writer that never causes a hazard, since rs = 0 is excluded from matching.

Reset
REQ-014 SHALL, while rsn_i is low, asynchronously clear all stage valid, rd and rd_we bits to 0.
REQ-015 SHALL hold every output at 0 during reset, since stall_o is qualified by stage state and by iss_valid_i.
REQ-016 SHALL discard all in-flight entries on a mid-operation reset, with no writeback afterwards.

Configuration
REQ-017 SHALL support the macro MULT_PIPE_CTRL_BYPASS_EN.
- Defined: the hazard window is S1..S4. A match on S5 sets byp_rs1_o and/or byp_rs2_o, with the same qualifiers as REQ-007, and does not stall.
- Undefined: the hazard window is S1..S5, and byp_rs1_o and byp_rs2_o are tied to 0.

Structure
REQ-018 SHALL place MUL_LAT, ALU_LAT, the M-extension funct7/opcode constants and the stage-entry struct typedef (valid, rd, rd_we) in the shared package mult_pkg.
REQ-019 SHALL contain one sub-module, mult_hazard_cmp, which compares one source register against all stage entries and returns a hit vector.
- It is instantiated twice, once for rs1 and once for rs2.

Verification
REQ-020 Back-to-back mults: issue MUL rd=5, then MUL rd=6 in the next cycle -> wb_we_o=1 with wb_addr_o=5 at t+5 and wb_addr_o=6 at t+6; stall_o=0 throughout.
REQ-021 RAW hazard: MUL rd=7 at t, then ADD rs1=7 at t+1 -> stall_o=1 for cycles t+1..t+5 without the bypass, or t+1..t+4 and byp_rs1_o=1 at t+5 with the bypass.
REQ-022 Writeback conflict: MUL rd=3 at t, then ADD rd=9 (independent) at t+3 -> stall_o=1 at t+3 only, and the ADD issues at t+4.
REQ-023 Kill: MUL rd=4 with kill_i=1 at t -> inflight_o stays 0, and no writeback occurs at t+5.
REQ-024 Reset mid-flight: three mults in flight, then rsn_i low for one cycle -> busy_o=0 and inflight_o=0 immediately, and no wb_we_o pulse follows.
REQ-025 x0 destination: MUL rd=0, then ADD rs1=0 -> stall_o=0.
